// File: rtl/mag_comp_pkg.sv
// Shared types for the serial magnitude comparator: FSM states, chunk
// compare results and an index-width helper.
package mag_comp_pkg;

   typedef enum logic [1:0] {IDLE, CMP, DONE} mc_state_t;

   typedef enum logic [1:0] {MC_EQ, MC_GT, MC_LT} mc_res_t;

   // Width of a counter addressing n entries; never narrower than one bit
   // so a single-chunk build still has a legal index register.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mag_comp_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice pair.
module mag_comp_chunk
   import mag_comp_pkg::*;
#(
   parameter int CHUNK = 2
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   output mc_res_t          res
);

   // Classify the slice pair; equality is the default outcome.
   always_comb begin
      res = MC_EQ;
      if (a > b) begin
         res = MC_GT;
      end else if (a < b) begin
         res = MC_LT;
      end
   end

endmodule

// File: rtl/mag_comp_serial.sv
// Serial magnitude comparator: compares two WIDTH-bit operands CHUNK bits
// per cycle, most significant chunk first, stopping at the first chunk that
// differs. Operands and results move through valid/ready handshakes.
// Optional feature macro: SIGNED_CMP_EN adds the signed_i port and a
// two's-complement compare mode (MSB flipped at capture, offset-binary).
module mag_comp_serial
   import mag_comp_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 2,
   localparam int NCHUNK = WIDTH / CHUNK,
   localparam int CW     = $clog2(NCHUNK + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
`ifdef SIGNED_CMP_EN
   input  logic             signed_i,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic             gt_o,
   output logic             eq_o,
   output logic             lt_o,
   output logic [CW-1:0]    cycles_o
);

   localparam int IW = idx_width(NCHUNK);
   localparam int NSLOT = 2 ** IW;
   localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

   mc_state_t        state;
   mc_state_t        state_next;
   logic [WIDTH-1:0] a_cap;
   logic [WIDTH-1:0] b_cap;
   logic [IW-1:0]    idx;
   logic [CW-1:0]    cnt;
   logic             accept;
   logic             flip;
   mc_res_t          chunk_res;

   // Slice tables padded to a power of two so idx never addresses past the end.
   logic [CHUNK-1:0] a_chunk [NSLOT];
   logic [CHUNK-1:0] b_chunk [NSLOT];

   generate
      for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slice
         if (gi < NCHUNK) begin : g_real
            assign a_chunk[gi] = a_cap[gi*CHUNK +: CHUNK];
            assign b_chunk[gi] = b_cap[gi*CHUNK +: CHUNK];
         end else begin : g_pad
            assign a_chunk[gi] = '0;
            assign b_chunk[gi] = '0;
         end
      end
   endgenerate

   mag_comp_chunk #(
      .CHUNK (CHUNK)
   ) u_chunk (
      .a   (a_chunk[idx]),
      .b   (b_chunk[idx]),
      .res (chunk_res)
   );

`ifdef SIGNED_CMP_EN
   assign flip = signed_i;
`else
   assign flip = 1'b0;
`endif

   assign accept = (state == IDLE) && in_valid;

   // State register; reset drops any compare in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_next = CMP;
            end
         end
         CMP: begin
            if (chunk_res != MC_EQ || idx == IW'(0)) begin
               state_next = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Operand capture, chunk walk and result registers. Results are only
   // rewritten when a new compare decides, so they persist into IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_cap    <= '0;
         b_cap    <= '0;
         idx      <= '0;
         cnt      <= '0;
         gt_o     <= 1'b0;
         eq_o     <= 1'b0;
         lt_o     <= 1'b0;
         cycles_o <= '0;
      end else if (accept) begin
         a_cap <= flip ? (a_i ^ MSB_MASK) : a_i;
         b_cap <= flip ? (b_i ^ MSB_MASK) : b_i;
         idx   <= IW'(NCHUNK - 1);
         cnt   <= '0;
      end else if (state == CMP) begin
         cnt <= cnt + CW'(1);
         if (chunk_res != MC_EQ || idx == IW'(0)) begin
            gt_o     <= (chunk_res == MC_GT);
            lt_o     <= (chunk_res == MC_LT);
            eq_o     <= (chunk_res == MC_EQ);
            cycles_o <= cnt + CW'(1);
         end else begin
            idx <= idx - IW'(1);
         end
      end
   end

endmodule

// File: tb/tb_mag_comp_serial.sv
// Directed self-checking bench for mag_comp_serial (WIDTH=16, CHUNK=2) plus a
// single-chunk instance (WIDTH=CHUNK=2) for the 2-bit truth table.
// Honours SIGNED_CMP_EN when defined.
module tb_mag_comp_serial;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a_i;
   logic [15:0] b_i;
   logic        sgn;
   logic        out_valid;
   logic        out_ready;
   logic        gt_o, eq_o, lt_o;
   logic [3:0]  cycles_o;

   logic        in_valid2;
   logic        in_ready2;
   logic [1:0]  a2, b2;
   logic        out_valid2;
   logic        out_ready2;
   logic        gt2, eq2, lt2;
   logic [0:0]  cycles2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mag_comp_serial #(.WIDTH(16), .CHUNK(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_i       (a_i),
      .b_i       (b_i),
`ifdef SIGNED_CMP_EN
      .signed_i  (sgn),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .gt_o      (gt_o),
      .eq_o      (eq_o),
      .lt_o      (lt_o),
      .cycles_o  (cycles_o)
   );

   mag_comp_serial #(.WIDTH(2), .CHUNK(2)) dut2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid2),
      .in_ready  (in_ready2),
      .a_i       (a2),
      .b_i       (b2),
`ifdef SIGNED_CMP_EN
      .signed_i  (1'b0),
`endif
      .out_valid (out_valid2),
      .out_ready (out_ready2),
      .gt_o      (gt2),
      .eq_o      (eq2),
      .lt_o      (lt2),
      .cycles_o  (cycles2)
   );

   // Drive one operand pair into dut and wait for out_valid. lat is the
   // number of edges after accept (-1 on timeout). scramble toggles the
   // operand pins every cycle while comparing; release completes the
   // output handshake straight away.
   task automatic do_compare(input logic [15:0] a, input logic [15:0] b,
                             input logic s, input bit scramble, input bit release_out,
                             output int lat);
      a_i = a; b_i = b; sgn = s; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         if (scramble) begin
            a_i = 16'($urandom); b_i = 16'($urandom); sgn = 1'($urandom);
         end
         @(posedge clk); #1;
         lat++;
      end
      if (!out_valid) lat = -1;
      if (release_out && lat >= 0) begin
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      int lat;
      rst_n = 1'b0;
      #12;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || {gt_o, eq_o, lt_o} !== 3'b000 || cycles_o !== 4'd0) begin
         errors++;
         $display("FAIL reset_hold: rdy=%b vld=%b gel=%b%b%b cyc=%0d required rdy=1 vld=0 gel=000 cyc=0",
                  in_ready, out_valid, gt_o, eq_o, lt_o, cycles_o);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      // Leave a non-zero result behind, then start a long compare and reset it mid-flight.
      do_compare(16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b1, lat);
      do_compare(16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, lat);
      $display("reset: result before abort gt=%b cyc=%0d", gt_o, cycles_o);
      // (that compare finished; now start another and abort it)
      out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
      a_i = 16'h1234; b_i = 16'h1234; in_valid = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0;
      @(posedge clk); @(posedge clk); #3;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_precond: in_ready=%b required 0 while comparing", in_ready);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || {gt_o, eq_o, lt_o} !== 3'b000 || cycles_o !== 4'd0) begin
         errors++;
         $display("FAIL reset_async: rdy=%b vld=%b gel=%b%b%b cyc=%0d required rdy=1 vld=0 gel=000 cyc=0",
                  in_ready, out_valid, gt_o, eq_o, lt_o, cycles_o);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_equal();
      int lat;
      do_compare(16'h1234, 16'h1234, 1'b0, 1'b0, 1'b1, lat);
      checks++;
      if ({gt_o, eq_o, lt_o} !== 3'b010 || cycles_o !== 4'd8 || lat != 8) begin
         errors++;
         $display("FAIL equal: gel=%b%b%b cyc=%0d lat=%0d required gel=010 cyc=8 lat=8",
                  gt_o, eq_o, lt_o, cycles_o, lat);
      end
      $display("equal: 1234 vs 1234 gel=%b%b%b cyc=%0d lat=%0d", gt_o, eq_o, lt_o, cycles_o, lat);
   endtask

   task automatic test_msb();
      int lat;
      do_compare(16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b1, lat);
      checks++;
      if ({gt_o, eq_o, lt_o} !== 3'b100 || cycles_o !== 4'd1 || lat != 1) begin
         errors++;
         $display("FAIL msb_unsigned: gel=%b%b%b cyc=%0d lat=%0d required gel=100 cyc=1 lat=1",
                  gt_o, eq_o, lt_o, cycles_o, lat);
      end
      $display("msb unsigned: 8000 vs 7fff gel=%b%b%b cyc=%0d", gt_o, eq_o, lt_o, cycles_o);
`ifdef SIGNED_CMP_EN
      do_compare(16'h8000, 16'h7FFF, 1'b1, 1'b0, 1'b1, lat);
      checks++;
      if ({gt_o, eq_o, lt_o} !== 3'b001 || cycles_o !== 4'd1 || lat != 1) begin
         errors++;
         $display("FAIL msb_signed: gel=%b%b%b cyc=%0d lat=%0d required gel=001 cyc=1 lat=1",
                  gt_o, eq_o, lt_o, cycles_o, lat);
      end
      $display("msb signed: 8000 vs 7fff gel=%b%b%b cyc=%0d", gt_o, eq_o, lt_o, cycles_o);
`endif
   endtask

   task automatic test_low_chunks();
      int lat;
      do_compare(16'h0003, 16'h0002, 1'b0, 1'b0, 1'b1, lat);
      checks++;
      if ({gt_o, eq_o, lt_o} !== 3'b100 || cycles_o !== 4'd8 || lat != 8) begin
         errors++;
         $display("FAIL lsb_gt: gel=%b%b%b cyc=%0d lat=%0d required gel=100 cyc=8 lat=8",
                  gt_o, eq_o, lt_o, cycles_o, lat);
      end
      $display("low: 0003 vs 0002 gel=%b%b%b cyc=%0d", gt_o, eq_o, lt_o, cycles_o);
      do_compare(16'h0040, 16'h0080, 1'b0, 1'b0, 1'b1, lat);
      checks++;
      if ({gt_o, eq_o, lt_o} !== 3'b001 || cycles_o !== 4'd5 || lat != 5) begin
         errors++;
         $display("FAIL mid_lt: gel=%b%b%b cyc=%0d lat=%0d required gel=001 cyc=5 lat=5",
                  gt_o, eq_o, lt_o, cycles_o, lat);
      end
      $display("mid: 0040 vs 0080 gel=%b%b%b cyc=%0d", gt_o, eq_o, lt_o, cycles_o);
   endtask

   task automatic test_backpressure();
      int lat;
      do_compare(16'h0040, 16'h0080, 1'b0, 1'b0, 1'b0, lat);
      checks++;
      if (lat != 5) begin
         errors++;
         $display("FAIL bp_latency: lat=%0d required 5", lat);
      end
      // Busy pins while the result waits must not disturb it.
      a_i = 16'hFFFF; b_i = 16'h0000; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || {gt_o, eq_o, lt_o} !== 3'b001 || cycles_o !== 4'd5) begin
            errors++;
            $display("FAIL bp_hold[%0d]: vld=%b rdy=%b gel=%b%b%b cyc=%0d required vld=1 rdy=0 gel=001 cyc=5",
                     i, out_valid, in_ready, gt_o, eq_o, lt_o, cycles_o);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || {gt_o, eq_o, lt_o} !== 3'b001 || cycles_o !== 4'd5) begin
         errors++;
         $display("FAIL bp_release: vld=%b rdy=%b gel=%b%b%b cyc=%0d required vld=0 rdy=1 gel=001 cyc=5",
                  out_valid, in_ready, gt_o, eq_o, lt_o, cycles_o);
      end
      $display("backpressure: held 5 cycles, released vld=%b rdy=%b", out_valid, in_ready);
   endtask

   task automatic test_input_change();
      int lat;
      do_compare(16'h0003, 16'h0002, 1'b0, 1'b1, 1'b1, lat);
      checks++;
      if ({gt_o, eq_o, lt_o} !== 3'b100 || cycles_o !== 4'd8 || lat != 8) begin
         errors++;
         $display("FAIL input_change: gel=%b%b%b cyc=%0d lat=%0d required gel=100 cyc=8 lat=8",
                  gt_o, eq_o, lt_o, cycles_o, lat);
      end
      $display("input change: 0003 vs 0002 with busy pins gel=%b%b%b cyc=%0d", gt_o, eq_o, lt_o, cycles_o);
   endtask

   task automatic test_truth_table();
      int lat;
      logic [2:0] want;
      for (int a = 0; a < 4; a++) begin
         for (int b = 0; b < 4; b++) begin
            want = (a > b) ? 3'b100 : (a == b) ? 3'b010 : 3'b001;
            a2 = 2'(a); b2 = 2'(b); in_valid2 = 1'b1;
            @(posedge clk); #1;
            in_valid2 = 1'b0;
            lat = 0;
            while (!out_valid2 && lat < 10) begin
               @(posedge clk); #1;
               lat++;
            end
            checks++;
            if ({gt2, eq2, lt2} !== want || cycles2 !== 1'b1 || lat != 1) begin
               errors++;
               $display("FAIL tt_%0d_%0d: gel=%b%b%b cyc=%0d lat=%0d required gel=%b cyc=1 lat=1",
                        a, b, gt2, eq2, lt2, cycles2, lat, want);
            end
            $display("tt: %0d vs %0d gel=%b%b%b", a, b, gt2, eq2, lt2);
            out_ready2 = 1'b1;
            @(posedge clk); #1;
            out_ready2 = 1'b0;
         end
      end
   endtask

   initial begin
      in_valid = 1'b0; out_ready = 1'b0; a_i = '0; b_i = '0; sgn = 1'b0;
      in_valid2 = 1'b0; out_ready2 = 1'b0; a2 = '0; b2 = '0;
      test_reset();
      test_equal();
      test_msb();
      test_low_chunks();
      test_backpressure();
      test_input_change();
      test_truth_table();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
